// File: rtl/fb_writer.sv
// Byte-wide framebuffer writer: streamed pixel bytes, SETADDR/FILL commands,
// and a registered read-first read port for the LCD scan engine.
module fb_writer #(
   parameter int unsigned FB_SIZE = 9600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   input  logic [31:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        busy,
   output logic        frame_done,
   output logic        addr_err
);

   localparam int unsigned AW = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
   localparam logic [AW-1:0] LAST = AW'(FB_SIZE - 1);

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] wr_ptr, wr_ptr_n;
   logic [AW-1:0] fill_cnt, fill_cnt_n;
   logic [7:0]    fill_byte, fill_byte_n;
   logic          busy_n, frame_done_n, addr_err_n;

   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;

   logic [7:0]    mem [FB_SIZE];

   assign cmd_ready = (state == IDLE) && rst_n;
   assign s_ready   = (state == IDLE) && !cmd_valid && rst_n;

   always_comb begin
      state_n      = state;
      wr_ptr_n     = wr_ptr;
      fill_cnt_n   = fill_cnt;
      fill_byte_n  = fill_byte;
      frame_done_n = 1'b0;
      addr_err_n   = 1'b0;
      we           = 1'b0;
      waddr        = wr_ptr;
      wdata        = s_data;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               if (cmd_op) begin
                  fill_byte_n = cmd_arg[7:0];
                  fill_cnt_n  = '0;
                  state_n     = FILL;
               end else if (cmd_arg < FB_SIZE) begin
                  wr_ptr_n = cmd_arg[AW-1:0];
               end else begin
                  wr_ptr_n   = '0;
                  addr_err_n = 1'b1;
               end
            end else if (s_valid && s_ready) begin
               we = 1'b1;
               if (wr_ptr == LAST) begin
                  wr_ptr_n     = '0;
                  frame_done_n = 1'b1;
               end else begin
                  wr_ptr_n = wr_ptr + AW'(1);
               end
            end
         end

         FILL: begin
            we    = 1'b1;
            waddr = fill_cnt;
            wdata = fill_byte;
            if (fill_cnt == LAST) begin
               state_n      = IDLE;
               wr_ptr_n     = '0;
               frame_done_n = 1'b1;
            end else begin
               fill_cnt_n = fill_cnt + AW'(1);
            end
         end

         default: state_n = IDLE;
      endcase

      busy_n = (state_n == FILL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         fill_byte  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         state      <= state_n;
         wr_ptr     <= wr_ptr_n;
         fill_cnt   <= fill_cnt_n;
         fill_byte  <= fill_byte_n;
         busy       <= busy_n;
         frame_done <= frame_done_n;
         addr_err   <= addr_err_n;
      end
   end

   // RAM is never cleared; a reset mid-FILL simply stops further writes.
   always_ff @(posedge clk) begin
      if (we && rst_n) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fb_data <= '0;
      end else if (fb_addr < FB_SIZE) begin
         fb_data <= mem[fb_addr[AW-1:0]];
      end else begin
         fb_data <= '0;
      end
   end

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer (FB_SIZE = 16): directed scenarios with
// literal expectations plus randomized traffic against a transaction-level model.
module tb_fb_writer;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_op = 1'b0;
   logic [31:0] cmd_arg = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_data = '0;
   logic [31:0] fb_addr = '0;
   logic [7:0]  fb_data;
   logic        busy;
   logic        frame_done;
   logic        addr_err;

   fb_writer #(.FB_SIZE(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .fb_addr(fb_addr), .fb_data(fb_data),
      .busy(busy), .frame_done(frame_done), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_mem [N];
   bit         m_known [N];
   int         m_ptr = 0;
   int         fill_left = 0;
   logic [7:0] fill_val = '0;
   logic       e_busy = 1'b0, e_fd = 1'b0, e_ae = 1'b0;
   logic [7:0] e_rd = '0;
   bit         e_rd_known = 1'b0;

   initial for (int i = 0; i < N; i++) m_known[i] = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         fill_left  = 0;
         m_ptr      = 0;
         e_busy     = 1'b0;
         e_fd       = 1'b0;
         e_ae       = 1'b0;
         e_rd       = 8'h00;
         e_rd_known = 1'b1;
      end else begin
         if (fb_addr < N) begin
            e_rd       = m_mem[fb_addr];
            e_rd_known = m_known[fb_addr];
         end else begin
            e_rd       = 8'h00;
            e_rd_known = 1'b1;
         end
         e_fd = 1'b0;
         e_ae = 1'b0;
         if (fill_left > 0) begin
            m_mem[N - fill_left]   = fill_val;
            m_known[N - fill_left] = 1'b1;
            fill_left--;
            if (fill_left == 0) begin
               m_ptr = 0;
               e_fd  = 1'b1;
            end
         end else if (cmd_valid) begin
            if (cmd_op) begin
               fill_val  = cmd_arg[7:0];
               fill_left = N;
            end else if (cmd_arg < N) begin
               m_ptr = int'(cmd_arg);
            end else begin
               m_ptr = 0;
               e_ae  = 1'b1;
            end
         end else if (s_valid) begin
            m_mem[m_ptr]   = s_data;
            m_known[m_ptr] = 1'b1;
            if (m_ptr == N - 1) e_fd = 1'b1;
            m_ptr = (m_ptr + 1) % N;
         end
         e_busy = (fill_left > 0);
      end
   end

   // ---------------- per-cycle compare + event monitor ----------------
   bit run_cmp = 1'b0;
   int fd_count = 0, ae_count = 0;
   int busy_run = 0, last_run = 0;
   bit prev_busy = 1'b0, fd_at_fall = 1'b0;

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("busy", busy, e_busy);
         chk("frame_done", frame_done, e_fd);
         chk("addr_err", addr_err, e_ae);
         chk("cmd_ready", cmd_ready, rst_n && fill_left == 0);
         chk("s_ready", s_ready, rst_n && fill_left == 0 && !cmd_valid);
         if (e_rd_known) chk("fb_data", fb_data, e_rd);
         fd_count += frame_done;
         ae_count += addr_err;
         if (busy) busy_run++;
         if (prev_busy && !busy) begin
            last_run   = busy_run;
            fd_at_fall = frame_done;
            busy_run   = 0;
         end
         prev_busy = busy;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_cmd(input logic op, input logic [31:0] arg);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         if (++n > 100) begin chk("cmd_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_byte(input logic [7:0] d);
      int n = 0;
      s_valid = 1'b1; s_data = d;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         if (++n > 100) begin chk("byte_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         if (++n > 100) begin chk("idle_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] exp);
      fb_addr = a;
      @(posedge clk); #1;
      chk($sformatf("read@%0h", a), fb_data, exp);
   endtask

   int fd0, ae0, n;

   initial begin
      repeat (3) @(posedge clk);
      run_cmp = 1'b1;
      #1;
      chk("rst_fb_data", fb_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FILL 0x5A
      fd0 = fd_count;
      do_cmd(1'b1, 32'h0000_FF5A);
      chk("busy_after_fill", busy, 1'b1);
      wait_idle();
      chk("busy_len", last_run, 16);
      chk("fd_at_busy_fall", fd_at_fall, 1'b1);
      chk("fill_fd_count", fd_count - fd0, 1);
      for (int a = 0; a < N; a++) rd(a, 8'h5A);

      // stream wrap
      fd0 = fd_count;
      do_cmd(1'b0, 32'd14);
      do_byte(8'hA1);
      do_byte(8'hA2);
      chk("fd_after_A2", frame_done, 1'b1);
      do_byte(8'hA3);
      chk("wrap_fd_count", fd_count - fd0, 1);
      do_byte(8'hB4);
      rd(14, 8'hA1); rd(15, 8'hA2); rd(0, 8'hA3); rd(1, 8'hB4);

      // priority: command wins over stream in the same cycle
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_arg = 32'd5;
      s_valid = 1'b1; s_data = 8'h99;
      @(negedge clk);
      chk("prio_s_ready", s_ready, 1'b0);
      chk("prio_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      s_valid = 1'b0;
      rd(5, 8'h99); rd(6, 8'h5A);

      // backpressure during FILL
      do_cmd(1'b1, 32'h11);
      s_valid = 1'b1; s_data = 8'h33;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         if (++n > 100) begin chk("bp_timeout", 0, 1); break; end
      end
      chk("bp_busy_low", busy, 1'b0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      rd(0, 8'h33); rd(1, 8'h11);

      // out-of-range SETADDR and read
      ae0 = ae_count;
      do_cmd(1'b0, 32'd16);
      chk("addr_err_pulse", addr_err, 1'b1);
      do_byte(8'h42);
      chk("addr_err_once", ae_count - ae0, 1);
      rd(0, 8'h42);
      rd(32'h20, 8'h00);

      // read/write collision returns old value first
      do_cmd(1'b0, 32'd3);
      fb_addr = 32'd3; s_valid = 1'b1; s_data = 8'h77;
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("collide_old", fb_data, 8'h11);
      @(posedge clk); #1;
      chk("collide_new", fb_data, 8'h77);

      // reset during fill cycle 5
      fd0 = fd_count;
      do_cmd(1'b1, 32'hC3);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("abort_no_fd", fd_count - fd0, 0);
      for (int a = 0; a < 5; a++) rd(a, 8'hC3);
      rd(5, 8'h11);
      for (int a = 6; a < N; a++) rd(a, 8'h11);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         cmd_valid = ($urandom_range(0, 9) < 2);
         cmd_op    = ($urandom_range(0, 19) == 0);
         cmd_arg   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 19));
         s_valid   = ($urandom_range(0, 1) == 1);
         s_data    = 8'($urandom);
         fb_addr   = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 19));
         @(posedge clk); #1;
      end
      rst_n = 1'b1; cmd_valid = 1'b0; s_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FB_SIZE, default 9600, framebuffer depth in bytes (320x240 at 1 bpp); legal range 2..2^24.
REQ-002 clk  input  1  sole clock; all state, RAM writes and RAM reads on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  input  1  0 = SETADDR, 1 = FILL.
REQ-007 cmd_arg  input  32  SETADDR: target address; FILL: fill byte in bits [7:0], bits [31:8] ignored.
REQ-008 s_valid  input  1  pixel byte offered.
REQ-009 s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-010 s_data  input  8  pixel byte.
REQ-011 fb_addr  input  32  read address from the LCD scan engine.
REQ-012 fb_data  output  8  registered read data.
REQ-013 busy  output  1  high while a FILL is in progress.
REQ-014 frame_done  output  1  one-cycle pulse on stream wrap or FILL completion.
REQ-015 addr_err  output  1  one-cycle pulse when SETADDR argument is out of range.

Function
REQ-016 Storage is an internal FB_SIZE x 8 RAM, with one write port and one read port, both clocked by clk; the LCD fb_clk is driven from this same clk.
REQ-017 Read latency: fb_data is updated on the rising edge after fb_addr is sampled; it holds ram[fb_addr] if fb_addr < FB_SIZE, else 0x00.
REQ-018 Read and write to the same address in the same cycle: fb_data returns the pre-write value (read-first).
REQ-019 States: IDLE and FILL only.
REQ-020 cmd_ready = (state == IDLE) && rst_n.
REQ-021 s_ready = (state == IDLE) && !cmd_valid && rst_n.
  - A pending command always has priority over stream data.
  - No stream byte is accepted in a command-accept cycle.
REQ-022 Write pointer wr_ptr is ceil(log2(FB_SIZE)) bits wide.
REQ-023 Accepted stream byte:
  - ram[wr_ptr] <= s_data.
  - wr_ptr <= (wr_ptr == FB_SIZE-1) ? 0 : wr_ptr+1.
  - frame_done pulses in the cycle after a write to FB_SIZE-1.
REQ-024 Accepted SETADDR, cmd_arg < FB_SIZE: wr_ptr <= cmd_arg; no RAM write.
REQ-025 Accepted SETADDR, cmd_arg >= FB_SIZE: wr_ptr <= 0 and addr_err pulses for one cycle the next cycle.
REQ-026 Accepted FILL:
  - Latch cmd_arg[7:0] as the fill byte; set fill counter to 0.
  - Enter FILL; busy goes high the next cycle.
REQ-027 In FILL, one byte is written per cycle at addresses 0,1,...,FB_SIZE-1 in order; exactly FB_SIZE write cycles.
REQ-028 After the write to FB_SIZE-1:
  - State returns to IDLE and busy deasserts.
  - wr_ptr <= 0.
  - frame_done pulses for one cycle, coincident with busy falling.
REQ-029 FILL is not interruptible except by reset; cmd_valid and s_valid asserted during FILL are held off (ready low), not dropped.
REQ-030 busy, frame_done and addr_err are registered outputs, with no combinational path from inputs.

Reset
REQ-031 While rst_n == 0 at a clock edge, the following take their reset values:
  - state = IDLE, wr_ptr = 0, fill counter = 0.
  - fb_data = 0x00, busy = 0, frame_done = 0, addr_err = 0.
  - cmd_ready = 0 and s_ready = 0 while rst_n is low.
REQ-032 RAM contents are not cleared by reset.
REQ-033 Reset during FILL aborts it; already-written bytes keep the fill value and the rest keep their old contents. After release, the block is in IDLE with no frame_done pulse.

Verification (bench FB_SIZE = 16)
REQ-034 Stream wrap: SETADDR 14, then stream 0xA1,0xA2,0xA3 -> ram[14]=0xA1, ram[15]=0xA2, ram[0]=0xA3; one frame_done pulse after the 0xA2 write; wr_ptr=1.
REQ-035 Fill: FILL 0x5A from IDLE -> busy high for exactly 16 cycles; reading fb_addr 0..15 returns 0x5A one cycle after each address; frame_done coincides with busy falling.
REQ-036 Priority and backpressure: cmd_valid and s_valid both high in IDLE -> s_ready low in that cycle and the command is accepted. s_valid held during FILL -> byte 0x33 is written at address 0 only after busy falls.
REQ-037 Error and out-of-range read: SETADDR 16 -> addr_err pulses once and the next stream byte lands at address 0. fb_addr = 0x20 -> fb_data = 0x00.
REQ-038 Collision and reset abort: a write of 0x77 to address 3 while fb_addr=3 -> the old value is returned, then 0x77 on the next read. rst_n low at fill cycle 5 -> addresses 0..4 hold the fill byte and 5..15 are unchanged; busy=0, no frame_done.
